// File: rtl/onchip_memory_avalon_pipelined_pkg.sv
// Purpose : shared types and helpers for the pipelined Avalon-MM on-chip RAM slave.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
package onchip_mem_pkg;

    // CLEAR: post-reset zero-fill in progress; READY: serving bus transfers.
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } mem_state_t;

    // Deepest supported read pipeline (RAM register + one output register).
    localparam int MAX_READ_LATENCY = 2;

    // Number of byte lanes in a data word.
    function automatic int lanes(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/onchip_memory_avalon_pipelined_if.sv
// Purpose : Avalon-MM slave bundle (request, response, sideband) for the on-chip RAM.
// Latency : n/a (wiring only).
// Backpr. : waitrequest is driven by the slave; the master holds its request while it is high.
// Ports   : master drives reset_req/clken/chipselect/read/write/address/byteenable/writedata;
//           slave drives readdata/readdatavalid/waitrequest/init_done.
interface onchip_memory_avalon_pipelined_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
);
    logic                  reset_req;
    logic                  clken;
    logic                  chipselect;
    logic                  read;
    logic                  write;
    logic [ADDR_W-1:0]     address;
    logic [DATA_W/8-1:0]   byteenable;
    logic [DATA_W-1:0]     writedata;
    logic [DATA_W-1:0]     readdata;
    logic                  readdatavalid;
    logic                  waitrequest;
    logic                  init_done;

    modport master (
        output reset_req, clken, chipselect, read, write, address, byteenable, writedata,
        input  readdata, readdatavalid, waitrequest, init_done
    );

    modport slave (
        input  reset_req, clken, chipselect, read, write, address, byteenable, writedata,
        output readdata, readdatavalid, waitrequest, init_done
    );
endinterface

// File: rtl/onchip_memory_avalon_pipelined_ram_core.sv
// Purpose : byte-enable single-port RAM, synchronous read, global enable; array is not reset.
// Latency : read data appears one enabled cycle after the address is presented.
// Backpr. : none; en_i=0 freezes both the array and the read register.
// Ports   : clk/rst, en_i, we_i, addr_i, be_i, wdata_i in; rdata_o out (read-first on writes).
module onchip_ram_core
    import onchip_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en_i,
    input  logic                       we_i,
    input  logic [ADDR_W-1:0]          addr_i,
    input  logic [lanes(DATA_W)-1:0]   be_i,
    input  logic [DATA_W-1:0]          wdata_i,
    output logic [DATA_W-1:0]          rdata_o
);
    localparam int LANES = lanes(DATA_W);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            for (int i = 0; i < LANES; i++) begin
                if (be_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    // Only the read register is reset so readdata starts at zero; storage stays uninitialised.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (en_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/onchip_memory_avalon_pipelined.sv
// Purpose : Avalon-MM on-chip RAM slave with optional post-reset zero-fill and 1/2-cycle reads.
// Latency : readdatavalid READ_LATENCY enabled cycles after an accepted read; 1 read/cycle.
// Backpr. : waitrequest while filling, while clken=0 or while reset_req=1; in-flight reads drain.
// Ports   : clk, reset (async, active-high); avs = slave side of the Avalon bundle.
module onchip_memory_avalon_pipelined
    import onchip_mem_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 12,
    parameter int READ_LATENCY   = 1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                              clk,
    input  logic                              reset,
    onchip_memory_avalon_pipelined_if.slave   avs
);
    localparam int LANES = lanes(DATA_W);

    if (DATA_W % 8 != 0 || DATA_W < 8 || DATA_W > 128) begin : g_bad_data_w
        $error("DATA_W must be a multiple of 8 in 8..128");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
        $error("READ_LATENCY must be 1 or 2");
    end

    mem_state_t          state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                init_done_q;
    logic                vld0_q;

    logic                wait_req;
    logic                accept;
    logic                wr_acc;
    logic                rd_acc;

    logic                ram_we;
    logic [ADDR_W-1:0]   ram_addr;
    logic [LANES-1:0]    ram_be;
    logic [DATA_W-1:0]   ram_wdata;
    logic [DATA_W-1:0]   ram_rdata;

    // State resets to CLEAR in every configuration so waitrequest is high during reset.
    assign wait_req = (state_q != READY) | ~avs.clken | avs.reset_req;
    assign accept   = avs.chipselect & (avs.read | avs.write) & ~wait_req;
    assign wr_acc   = accept & avs.write;
    // A simultaneous read+write is treated as a write only.
    assign rd_acc   = accept & avs.read & ~avs.write;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ram_we    = 1'b0;
        ram_addr  = avs.address;
        ram_be    = avs.byteenable;
        ram_wdata = avs.writedata;
        case (state_q)
            CLEAR: begin
                if (!CLEAR_ON_RESET) begin
                    state_d = READY;
                end else begin
                    // The RAM enable is clken, so the fill advances only on enabled cycles.
                    ram_addr  = cnt_q;
                    ram_be    = '1;
                    ram_wdata = '0;
                    ram_we    = 1'b1;
                    if (avs.clken) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == '1) begin
                            state_d = READY;
                        end
                    end
                end
            end
            READY: begin
                ram_we = wr_acc;
            end
            default: state_d = READY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= CLEAR;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= (state_d == READY);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld0_q <= 1'b0;
        end else if (avs.clken) begin
            vld0_q <= rd_acc;
        end
    end

    onchip_ram_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst     (reset),
        .en_i    (avs.clken),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .be_i    (ram_be),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    if (READ_LATENCY == 2) begin : g_lat2
        logic              vld1_q;
        logic [DATA_W-1:0] rdata2_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                vld1_q   <= 1'b0;
                rdata2_q <= '0;
            end else if (avs.clken) begin
                vld1_q   <= vld0_q;
                rdata2_q <= ram_rdata;
            end
        end

        assign avs.readdatavalid = vld1_q;
        assign avs.readdata      = rdata2_q;
    end else begin : g_lat1
        assign avs.readdatavalid = vld0_q;
        assign avs.readdata      = ram_rdata;
    end

    assign avs.waitrequest = wait_req;
    assign avs.init_done   = init_done_q;
endmodule

// File: tb/tb_onchip_memory_avalon_pipelined.sv
// Purpose : self-checking bench for onchip_memory_avalon_pipelined (ADDR_W=4, READ_LATENCY=2).
// Latency : reference model tracks each read's due cycle in enabled clocks.
// Backpr. : model predicts waitrequest from fill progress, clken and reset_req.
module tb_onchip_memory_avalon_pipelined;
    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int LAT   = 2;
    localparam int DEPTH = 1 << AW;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } rd_t;

    logic clk;
    logic reset;

    onchip_memory_avalon_pipelined_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    onchip_memory_avalon_pipelined #(
        .DATA_W         (DW),
        .ADDR_W         (AW),
        .READ_LATENCY   (LAT),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .avs   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state.
    logic [DW-1:0] mdl [DEPTH];
    rd_t           q[$];
    int            fill_left;
    int            en_edges;
    bit            in_reset;
    logic [DW-1:0] last_rd;
    int            checks;
    int            failures;

    task automatic idle();
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.clken      = 1'b1;
        bus.reset_req  = 1'b0;
        bus.address    = '0;
        bus.byteenable = '0;
        bus.writedata  = '0;
    endtask

    // One clock: check outputs against the model, update the model, advance to next negedge.
    task automatic step();
        bit exp_wait;
        bit exp_vld;
        bit acc;
        #1;
        exp_wait = in_reset || fill_left != 0 || !bus.clken || bus.reset_req;
        checks++;
        if (bus.waitrequest !== exp_wait) begin
            failures++;
            $display("FAIL waitrequest t=%0t: got %b expected %b", $time, bus.waitrequest, exp_wait);
        end
        checks++;
        if (bus.init_done !== (!in_reset && fill_left == 0)) begin
            failures++;
            $display("FAIL init_done t=%0t: got %b expected %b", $time, bus.init_done,
                     (!in_reset && fill_left == 0));
        end
        if (in_reset) begin
            checks++;
            if (bus.readdatavalid !== 1'b0) begin
                failures++;
                $display("FAIL rdv_in_reset t=%0t: got %b expected 0", $time, bus.readdatavalid);
            end
        end else if (bus.clken) begin
            exp_vld = (q.size() > 0) && (q[0].due == en_edges);
            checks++;
            if (bus.readdatavalid !== exp_vld) begin
                failures++;
                $display("FAIL readdatavalid t=%0t: got %b expected %b", $time,
                         bus.readdatavalid, exp_vld);
            end
            if (exp_vld) begin
                checks++;
                if (bus.readdata !== q[0].data) begin
                    failures++;
                    $display("FAIL readdata t=%0t: got %h expected %h", $time,
                             bus.readdata, q[0].data);
                end
                last_rd = bus.readdata;
                void'(q.pop_front());
            end
        end
        acc = bus.chipselect && (bus.read || bus.write) && !exp_wait;
        if (acc && bus.write) begin
            for (int i = 0; i < DW / 8; i++) begin
                if (bus.byteenable[i]) mdl[bus.address][8*i +: 8] = bus.writedata[8*i +: 8];
            end
        end else if (acc && bus.read) begin
            q.push_back('{data: mdl[bus.address], due: en_edges + LAT});
        end
        if (bus.clken && !in_reset) begin
            en_edges++;
            if (fill_left > 0) fill_left--;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic req(input bit rd, input bit wr, input int addr,
                       input logic [DW-1:0] d, input logic [DW/8-1:0] be);
        bus.chipselect = 1'b1;
        bus.read       = rd;
        bus.write      = wr;
        bus.address    = addr[AW-1:0];
        bus.writedata  = d;
        bus.byteenable = be;
        step();
        idle();
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < 20 && q.size() > 0; i++) step();
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d reads never returned, expected 0", q.size());
        end
    endtask

    task automatic do_reset(input bit check_outputs);
        reset    = 1'b1;
        in_reset = 1'b1;
        q.delete();
        #1;
        if (check_outputs) begin
            checks++;
            if (bus.readdata !== '0) begin
                failures++;
                $display("FAIL reset_readdata: got %h expected 0", bus.readdata);
            end
            checks++;
            if (bus.readdatavalid !== 1'b0) begin
                failures++;
                $display("FAIL reset_rdv: got %b expected 0", bus.readdatavalid);
            end
            checks++;
            if (bus.waitrequest !== 1'b1) begin
                failures++;
                $display("FAIL reset_waitrequest: got %b expected 1", bus.waitrequest);
            end
            checks++;
            if (bus.init_done !== 1'b0) begin
                failures++;
                $display("FAIL reset_init_done: got %b expected 0", bus.init_done);
            end
        end
        step();
        step();
        reset     = 1'b0;
        in_reset  = 1'b0;
        fill_left = DEPTH;
        foreach (mdl[i]) mdl[i] = '0;
    endtask

    task automatic test_reset();
        do_reset(1'b1);
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) step();
        for (int a = 0; a < DEPTH; a++) req(1'b1, 1'b0, a, '0, '0);
        drain();
    endtask

    task automatic test_lane_write();
        req(1'b0, 1'b1, 5, 32'hAABBCCDD, 4'b1111);
        req(1'b0, 1'b1, 5, 32'h11223344, 4'b0101);
        req(1'b1, 1'b0, 5, '0, '0);
        drain();
        checks++;
        if (last_rd !== 32'hAA22CC44) begin
            failures++;
            $display("FAIL lane_write: got %h expected aa22cc44", last_rd);
        end
        req(1'b0, 1'b1, 6, 32'hDEADBEEF, 4'b0000);
        req(1'b1, 1'b0, 6, '0, '0);
        drain();
    endtask

    task automatic test_back_to_back();
        for (int a = 1; a <= 3; a++) req(1'b0, 1'b1, a, a, 4'hF);
        for (int a = 1; a <= 3; a++) req(1'b1, 1'b0, a, '0, '0);
        drain();
        checks++;
        if (last_rd !== 32'd3) begin
            failures++;
            $display("FAIL back_to_back_last: got %h expected 3", last_rd);
        end
    endtask

    task automatic test_freeze();
        req(1'b1, 1'b0, 2, '0, '0);
        bus.clken      = 1'b0;
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        bus.address    = 4'd9;
        for (int i = 0; i < 3; i++) step();
        drain();
        checks++;
        if (last_rd !== 32'd2) begin
            failures++;
            $display("FAIL freeze_data: got %h expected 2", last_rd);
        end
    endtask

    task automatic test_collision_and_stall();
        req(1'b1, 1'b1, 7, 32'h5A, 4'hF);
        drain();
        req(1'b1, 1'b0, 7, '0, '0);
        drain();
        checks++;
        if (last_rd !== 32'h5A) begin
            failures++;
            $display("FAIL collision_data: got %h expected 5a", last_rd);
        end
        req(1'b1, 1'b0, 3, '0, '0);
        bus.reset_req  = 1'b1;
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        bus.address    = 4'd4;
        for (int i = 0; i < 4; i++) step();
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bus.chipselect = ($urandom_range(0, 3) != 0);
            bus.read       = $urandom_range(0, 1);
            bus.write      = $urandom_range(0, 2) == 0;
            bus.address    = $urandom_range(0, DEPTH - 1);
            bus.byteenable = $urandom_range(0, 15);
            bus.writedata  = $urandom;
            bus.clken      = ($urandom_range(0, 7) != 0);
            bus.reset_req  = ($urandom_range(0, 7) == 0);
            step();
        end
        drain();
    endtask

    task automatic test_reset_mid_fill();
        req(1'b0, 1'b1, 9, 32'h12345678, 4'hF);
        req(1'b1, 1'b0, 9, '0, '0);
        do_reset(1'b0);
        for (int i = 0; i < 9; i++) step();
        do_reset(1'b0);
        for (int i = 0; i < 4 * DEPTH && fill_left > 0; i++) begin
            bus.clken = !(i == 4 || i == 5);
            step();
        end
        idle();
        checks++;
        if (fill_left != 0) begin
            failures++;
            $display("FAIL refill_timeout: %0d fill cycles left, expected 0", fill_left);
        end
        req(1'b1, 1'b0, 9, '0, '0);
        drain();
        checks++;
        if (last_rd !== '0) begin
            failures++;
            $display("FAIL refill_data: got %h expected 0", last_rd);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        en_edges  = 0;
        fill_left = DEPTH;
        in_reset  = 1'b1;
        last_rd   = 'x;
        idle();
        test_reset();
        test_fill();
        test_lane_write();
        test_back_to_back();
        test_freeze();
        test_collision_and_stall();
        test_random();
        test_reset_mid_fill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
